// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and constants for the branch resolve unit
//
// Purpose: funct3 condition codes, the operation-kind enum and the packed
// result record held in the output register of branch_resolve_unit.
// Ports: none (package).
package branch_pkg;

    // Widest XLEN the result record can carry; narrower builds zero-extend.
    localparam int BR_XLEN_MAX = 64;

    localparam logic [2:0] COMP_EQ  = 3'b000;
    localparam logic [2:0] COMP_NE  = 3'b001;
    localparam logic [2:0] COMP_LT  = 3'b100;
    localparam logic [2:0] COMP_GE  = 3'b101;
    localparam logic [2:0] COMP_LTU = 3'b110;
    localparam logic [2:0] COMP_GEU = 3'b111;

    typedef enum logic [1:0] {
        KIND_NONE   = 2'b00,
        KIND_BRANCH = 2'b01,
        KIND_JAL    = 2'b10,
        KIND_JALR   = 2'b11
    } br_kind_t;

    typedef struct packed {
        logic                   taken;
        logic                   mispredict;
        logic [BR_XLEN_MAX-1:0] target;
        logic [BR_XLEN_MAX-1:0] link;
        br_kind_t               kind;
    } br_result_t;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - combinational RV32I branch condition evaluator
//
// Purpose: evaluates one of the six funct3 branch conditions on a and b.
// Ports:
//   a_i, b_i     XLEN  operands (rs1, rs2)
//   comp_ctrl_i  3     funct3 condition code
//   cond_o       1     condition result (0 for the unused codes 010/011)
module branch_cond
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      comp_ctrl_i,
    output logic            cond_o
);

    always_comb begin
        cond_o = 1'b0;
        case (comp_ctrl_i)
            COMP_EQ:  cond_o = (a_i == b_i);
            COMP_NE:  cond_o = (a_i != b_i);
            // Both operands cast together so the comparison is truly signed.
            COMP_LT:  cond_o = ($signed(a_i) <  $signed(b_i));
            COMP_GE:  cond_o = ($signed(a_i) >= $signed(b_i));
            COMP_LTU: cond_o = (a_i <  b_i);
            COMP_GEU: cond_o = (a_i >= b_i);
            default:  cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered branch/JAL/JALR resolution stage
//
// Purpose: resolves taken/target/link/mispredict for one request per cycle,
// holds it in a single output register with valid/ready on both sides, and
// keeps saturating counters of completed control-flow ops.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   in_valid/in_ready                   request handshake
//   in_a, in_b, in_pc, in_imm           operands, PC, sign-extended immediate
//   in_comp_ctrl, in_kind, in_pred_taken  condition, op kind, prediction
//   flush                               drop held result and same-cycle input
//   out_valid/out_ready                 result handshake
//   out_taken, out_target, out_link, out_mispredict  resolved result
//   cnt_branch, cnt_taken, cnt_mispredict           saturating counters
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [2:0]       in_comp_ctrl,
    input  logic [1:0]       in_kind,
    input  logic             in_pred_taken,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_link,
    output logic             out_mispredict,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_mispredict
);

    br_kind_t        kind_w;
    logic            cond_w;
    logic            taken_w;
    logic [XLEN-1:0] target_w;
    logic [XLEN-1:0] jalr_sum_w;
    br_result_t      res_d, res_q;
    logic            valid_q;
    logic [CNT_W-1:0] cnt_branch_q, cnt_taken_q, cnt_mispredict_q;
    logic            capture_w;
    logic            out_hs_w;

    assign kind_w = br_kind_t'(in_kind);

    branch_cond #(.XLEN(XLEN)) u_cond (
        .a_i         (in_a),
        .b_i         (in_b),
        .comp_ctrl_i (in_comp_ctrl),
        .cond_o      (cond_w)
    );

    assign jalr_sum_w = in_a + in_imm;

    always_comb begin
        taken_w  = 1'b0;
        target_w = in_pc + XLEN'(4);
        case (kind_w)
            KIND_BRANCH: begin
                taken_w  = cond_w;
                target_w = in_pc + in_imm;
            end
            KIND_JAL: begin
                taken_w  = 1'b1;
                target_w = in_pc + in_imm;
            end
            KIND_JALR: begin
                taken_w  = 1'b1;
                target_w = jalr_sum_w & ~XLEN'(1);
            end
            default: begin
                taken_w  = 1'b0;
                target_w = in_pc + XLEN'(4);
            end
        endcase
    end

    always_comb begin
        res_d            = '0;
        res_d.taken      = taken_w;
        res_d.mispredict = taken_w ^ in_pred_taken;
        res_d.target     = BR_XLEN_MAX'(target_w);
        res_d.link       = BR_XLEN_MAX'(in_pc + XLEN'(4));
        res_d.kind       = kind_w;
    end

    // Ready whenever the slot is empty or being drained this cycle.
    assign in_ready  = !valid_q || out_ready;
    assign capture_w = in_valid && in_ready && !flush;
    assign out_hs_w  = valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            res_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture_w) begin
            valid_q <= 1'b1;
            res_q   <= res_d;
        end else if (out_hs_w) begin
            valid_q <= 1'b0;
        end
    end

    // Counters follow the output handshake, which still counts during flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_branch_q     <= '0;
            cnt_taken_q      <= '0;
            cnt_mispredict_q <= '0;
        end else if (out_hs_w && (res_q.kind != KIND_NONE)) begin
            if (cnt_branch_q != {CNT_W{1'b1}})
                cnt_branch_q <= cnt_branch_q + CNT_W'(1);
            if (res_q.taken && (cnt_taken_q != {CNT_W{1'b1}}))
                cnt_taken_q <= cnt_taken_q + CNT_W'(1);
            if (res_q.mispredict && (cnt_mispredict_q != {CNT_W{1'b1}}))
                cnt_mispredict_q <= cnt_mispredict_q + CNT_W'(1);
        end
    end

    assign out_valid      = valid_q;
    assign out_taken      = res_q.taken;
    assign out_mispredict = res_q.mispredict;
    assign out_target     = res_q.target[XLEN-1:0];
    assign out_link       = res_q.link[XLEN-1:0];
    assign cnt_branch     = cnt_branch_q;
    assign cnt_taken      = cnt_taken_q;
    assign cnt_mispredict = cnt_mispredict_q;

    // Upper record bits are constant zero when XLEN is below the record width.
    if (XLEN < BR_XLEN_MAX) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^{res_q.target[BR_XLEN_MAX-1:XLEN],
                             res_q.link[BR_XLEN_MAX-1:XLEN]};
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0, in_pc = '0, in_imm = '0;
    logic [2:0]  in_comp_ctrl = '0;
    logic [1:0]  in_kind = '0;
    logic        in_pred_taken = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_taken;
    logic [31:0] out_target, out_link;
    logic        out_mispredict;
    logic [1:0]  cnt_branch, cnt_taken, cnt_mispredict;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_imm(in_imm),
        .in_comp_ctrl(in_comp_ctrl), .in_kind(in_kind), .in_pred_taken(in_pred_taken),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target), .out_link(out_link),
        .out_mispredict(out_mispredict),
        .cnt_branch(cnt_branch), .cnt_taken(cnt_taken), .cnt_mispredict(cnt_mispredict)
    );

    typedef struct {
        logic        taken;
        logic        mis;
        logic [31:0] target;
        logic [31:0] link;
        logic        counts;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [1:0] m_b = 0, m_t = 0, m_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drives one request (caller is aligned just after a posedge) and pushes
    // the hand-computed expectation once the request is accepted.
    task automatic send(input logic [1:0] kind, input logic [2:0] cc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic pred, input logic e_taken,
                        input logic [31:0] e_target, input logic [31:0] e_link);
        exp_t e;
        int   waited;
        in_valid = 1'b1; in_kind = kind; in_comp_ctrl = cc;
        in_a = a; in_b = b; in_pc = pc; in_imm = imm; in_pred_taken = pred;
        e.taken = e_taken; e.mis = e_taken ^ pred; e.target = e_target;
        e.link = e_link; e.counts = (kind != 2'b00);
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                break;
            end
            waited++;
            if (waited > 20) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: in_ready stuck low");
                break;
            end
        end
        sync();
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
        end
        sync();
    endtask

    // Monitor: counters against the saturating model every cycle, results
    // against the queue front whenever out_valid is high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                m_b = 0; m_t = 0; m_m = 0;
            end else begin
                chk("cnt_branch", 32'(cnt_branch), 32'(m_b));
                chk("cnt_taken", 32'(cnt_taken), 32'(m_t));
                chk("cnt_mispredict", 32'(cnt_mispredict), 32'(m_m));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_valid: out_valid=1 with nothing expected");
                    end else begin
                        e = exp_q[0];
                        chk("out_taken", 32'(out_taken), 32'(e.taken));
                        chk("out_mispredict", 32'(out_mispredict), 32'(e.mis));
                        chk("out_target", out_target, e.target);
                        chk("out_link", out_link, e.link);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            if (e.counts) begin
                                if (m_b != 2'd3) m_b++;
                                if (e.taken && m_t != 2'd3) m_t++;
                                if (e.mis && m_m != 2'd3) m_m++;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_taken", 32'(out_taken), 32'd0);
        chk("rst_out_mispredict", 32'(out_mispredict), 32'd0);
        chk("rst_out_target", out_target, 32'd0);
        chk("rst_out_link", out_link, 32'd0);
        sync();

        // Directed vectors, streamed at full throughput
        //    kind   cc      a             b             pc            imm           pred tk target        link
        send(2'b01, 3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000200, 32'h00000010, 0, 1, 32'h00000210, 32'h00000204);
        send(2'b01, 3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000200, 32'h00000010, 0, 0, 32'h00000210, 32'h00000204);
        send(2'b01, 3'b101, 32'h80000000, 32'h80000000, 32'h00000300, 32'h00000008, 1, 1, 32'h00000308, 32'h00000304);
        send(2'b01, 3'b000, 32'h00000005, 32'h00000005, 32'h00000100, 32'hFFFFFFF0, 1, 1, 32'h000000F0, 32'h00000104);
        send(2'b11, 3'b000, 32'h00001001, 32'h00000000, 32'h00000400, 32'h00000004, 1, 1, 32'h00001004, 32'h00000404);
        send(2'b01, 3'b010, 32'h00000000, 32'h00000000, 32'h00000500, 32'h00000020, 1, 0, 32'h00000520, 32'h00000504);
        send(2'b00, 3'b000, 32'h00000000, 32'h00000000, 32'hFFFFFFFC, 32'h00000040, 0, 0, 32'h00000000, 32'h00000000);
        send(2'b01, 3'b001, 32'h00000001, 32'h00000002, 32'h00000600, 32'hFFFFFF00, 0, 1, 32'h00000500, 32'h00000604);
        send(2'b01, 3'b111, 32'h00000001, 32'hFFFFFFFF, 32'h00000700, 32'h00000040, 0, 0, 32'h00000740, 32'h00000704);
        send(2'b10, 3'b000, 32'h00000000, 32'h00000000, 32'h00000800, 32'hFFFFF800, 0, 1, 32'h00000000, 32'h00000804);
        wait_empty();

        // Backpressure: second request waits while the first is held
        out_ready = 1'b0;
        send(2'b10, 3'b000, 32'h0, 32'h0, 32'h00001000, 32'h00000020, 1, 1, 32'h00001020, 32'h00001004);
        fork
            send(2'b01, 3'b011, 32'h0, 32'h0, 32'h00002000, 32'h00000008, 1, 0, 32'h00002008, 32'h00002004);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_out_valid", 32'(out_valid), 32'd1);
                end
                sync();
                out_ready = 1'b1;
            end
        join
        wait_empty();

        // Flush while holding a result under backpressure with a new request
        out_ready = 1'b0;
        send(2'b10, 3'b000, 32'h0, 32'h0, 32'h00000900, 32'h00000010, 0, 1, 32'h00000910, 32'h00000904);
        flush = 1'b1; in_valid = 1'b1; in_kind = 2'b10; in_pc = 32'h00000A00;
        sync();
        flush = 1'b0; in_valid = 1'b0;
        void'(exp_q.pop_front());
        repeat (2) begin
            @(negedge clk);
            chk("flush_out_valid", 32'(out_valid), 32'd0);
        end
        sync();
        out_ready = 1'b1;

        // Flush with a draining handshake: drained result counts, input dropped
        send(2'b01, 3'b000, 32'h7, 32'h7, 32'h00000B00, 32'h00000004, 0, 1, 32'h00000B04, 32'h00000B04);
        flush = 1'b1; in_valid = 1'b1; in_kind = 2'b11; in_pc = 32'h00000C00;
        sync();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush2_out_valid", 32'(out_valid), 32'd0);
        sync();

        // Saturation: five taken mispredicted JALs from a clean counter state
        reset = 1'b1;
        sync();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(2'b10, 3'b000, 32'h0, 32'h0, 32'h00003000 + 32'(i * 4), 32'h00000100, 0, 1,
                 32'h00003100 + 32'(i * 4), 32'h00003004 + 32'(i * 4));
        end
        wait_empty();
        @(negedge clk);
        chk("sat_cnt_branch", 32'(cnt_branch), 32'd3);
        chk("sat_cnt_taken", 32'(cnt_taken), 32'd3);
        chk("sat_cnt_mispredict", 32'(cnt_mispredict), 32'd3);
        sync();
        for (int i = 0; i < 5; i++) begin
            send(2'b00, 3'b000, 32'h0, 32'h0, 32'h00004000, 32'h00000000, 1, 0, 32'h00004004, 32'h00004004);
        end
        wait_empty();
        @(negedge clk);
        chk("none_cnt_branch", 32'(cnt_branch), 32'd3);
        chk("none_cnt_taken", 32'(cnt_taken), 32'd3);
        chk("none_cnt_mispredict", 32'(cnt_mispredict), 32'd3);
        sync();

        // Reset mid-stream with a result in flight and a request pending
        send(2'b10, 3'b000, 32'h0, 32'h0, 32'h00005000, 32'h00000010, 0, 1, 32'h00005010, 32'h00005004);
        reset = 1'b1; in_valid = 1'b1; in_kind = 2'b11;
        sync();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_cnt_branch", 32'(cnt_branch), 32'd0);
        chk("midrst_cnt_taken", 32'(cnt_taken), 32'd0);
        chk("midrst_cnt_mispredict", 32'(cnt_mispredict), 32'd0);
        sync();
        sync();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised, registered branch/jump resolution unit for the RV32I core, successor to the combinational branch comparator.
- Resolves conditional branches (all six RV32I conditions), JAL and JALR.
- Computes the target address and link value, and flags mispredictions against a supplied prediction.
- Has valid/ready handshakes on both sides, a flush input, and saturating performance counters.
- Sits between decode/operand read and the PC-select/fetch-redirect logic.

Parameters:
XLEN, 32, operand/PC/immediate width (>= 8)
CNT_W, 16, width of each performance counter (>= 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept request
in_a  in  XLEN  rs1 value
in_b  in  XLEN  rs2 value
in_pc  in  XLEN  PC of the instruction
in_imm  in  XLEN  sign-extended immediate
in_comp_ctrl  in  3  branch condition (funct3 encoding)
in_kind  in  2  NONE=00, BRANCH=01, JAL=10, JALR=11
in_pred_taken  in  1  front-end prediction
flush  in  1  discard held/incoming result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_taken  out  1  resolved taken
out_target  out  XLEN  redirect target (PC-relative or JALR)
out_link  out  XLEN  in_pc + 4
out_mispredict  out  1  resolved taken != in_pred_taken
cnt_branch  out  CNT_W  completed BRANCH/JAL/JALR ops
cnt_taken  out  CNT_W  completed ops with taken=1
cnt_mispredict  out  CNT_W  completed ops with mispredict=1

Behaviour:
- Reset (synchronous, active-high): out_valid=0; out_taken, out_mispredict, out_target, out_link, all counters = 0. Reset overrides flush and all handshakes.
- Single output register stage; latency 1 cycle from input handshake to out_valid.
- in_ready = !out_valid || out_ready (combinational, no bubble under full throughput).
- Capture when in_valid && in_ready && !flush. All outputs update together on capture.
- If out_valid && !out_ready, the held result is stable; in_a..in_pred_taken are ignored.
- Conditions:
  - EQ 000: a==b
  - NE 001: a!=b
  - LT 100: signed a<b
  - GE 101: signed a>=b
  - LTU 110: unsigned a<b
  - GEU 111: unsigned a>=b
  - Codes 010/011: not taken.
  - Both operands are compared with the same signedness.
- Taken by kind: BRANCH = condition result; JAL/JALR = 1; NONE = 0.
- Target:
  - BRANCH/JAL: pc+imm.
  - JALR: (a+imm) with bit 0 cleared.
  - NONE: pc+4.
  - All sums are modulo 2^XLEN; no overflow flag.
- out_link = pc+4, modulo 2^XLEN.
- out_mispredict = taken XOR pred_taken, for every kind including NONE.
- flush:
  - Next cycle out_valid=0, regardless of out_ready.
  - A same-cycle input is not captured; in_ready may be high but the transfer is dropped.
  - A handshake on out_* in the flush cycle still counts.
- Counters:
  - Update only on output handshake (out_valid && out_ready), counting only kind != NONE.
  - Each counter saturates at 2^CNT_W-1; no wrap.
  - Increments are independent per counter.

Decomposition:
- Package branch_pkg holds:
  - comp_ctrl constants COMP_EQ/NE/LT/GE/LTU/GEU (funct3 values above).
  - br_kind_t enum (NONE, BRANCH, JAL, JALR).
  - A packed br_result_t struct (taken, mispredict, target, link, kind).
- One natural sub-module, branch_cond: purely combinational condition evaluator (a, b, comp_ctrl -> cond), correct signed/unsigned handling.
- Counters, the output register and the handshake stay in the top module.

Test Plan:
- BRANCH LT, a=0xFFFFFFFF, b=1, pred=0 -> out_taken=1, out_mispredict=1. Same operands with LTU -> taken=0, mispredict=0. GE with a=b=0x80000000 -> taken=1.
- BRANCH EQ, pc=0x100, imm=0xFFFFFFF0, a=b -> target=0xF0, link=0x104. JALR a=0x1001, imm=4 -> target=0x1004, taken=1. comp_ctrl=010 -> taken=0.
- Backpressure: two back-to-back requests, out_ready=0 for 3 cycles:
  - in_ready=0 and first result held stable throughout.
  - out_ready=1 -> both results delivered in order on consecutive cycles.
- Flush while out_valid=1, out_ready=0, and in_valid=1 -> next cycle out_valid=0, counters unchanged, request dropped.
- CNT_W=2: five taken mispredicted JALs drained -> all counters stick at 3. Five NONE ops -> counters unchanged. Reset asserted mid-stream -> counters 0 and out_valid=0 next cycle.
